// File: rtl/lsu_bus_ctrl_pkg.sv
// ============================================================================
// Module   : lsu_bus_ctrl_pkg
// Purpose  : Shared encodings, FSM states and helpers for the LSU bus controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_bus_ctrl_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_BE_W   = c_DATA_W / 8;

    // Load op encodings; bits [1:0] give the access size, bit 2 selects zero-extension.
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    localparam logic [1:0] c_SB = 2'b00;
    localparam logic [1:0] c_SH = 2'b01;
    localparam logic [1:0] c_SW = 2'b10;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_REQ  = 2'b01;
    localparam logic [1:0] c_ST_RESP = 2'b10;
    localparam logic [1:0] c_ST_DONE = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            c_SZ_BYTE: r = 1'b0;
            c_SZ_HALF: r = off[0];
            default:   r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_bus_ctrl_if.sv
// ============================================================================
// Module   : lsu_bus_ctrl_if
// Purpose  : Data-bus request/ready/rvalid interface between LSU and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lsu_bus_ctrl_if;
    import lsu_bus_ctrl_pkg::*;

    logic                dbus_req;
    logic                dbus_write;
    logic [c_DATA_W-1:0] dbus_addr;
    logic [c_DATA_W-1:0] dbus_wdata;
    logic [c_BE_W-1:0]   dbus_byte_en;
    logic                dbus_ready;
    logic                dbus_rvalid;
    logic [c_DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_byte_en,
        input  dbus_ready, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_write, dbus_addr, dbus_wdata, dbus_byte_en,
        output dbus_ready, dbus_rvalid, dbus_rdata
    );

endinterface

`default_nettype wire

// File: rtl/lsu_bus_ctrl_align.sv
// ============================================================================
// Module   : lsu_bus_ctrl_align
// Purpose  : Store lane replication / byte enables and load extract / extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_bus_ctrl_align
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [1:0]          st_size_i,
    input  logic [1:0]          st_off_i,
    input  logic [c_DATA_W-1:0] st_data_i,
    output logic [c_DATA_W-1:0] st_wdata_o,
    output logic [c_BE_W-1:0]   st_be_o,
    input  logic [2:0]          ld_op_i,
    input  logic [1:0]          ld_off_i,
    input  logic [c_DATA_W-1:0] ld_word_i,
    output logic [c_DATA_W-1:0] ld_data_o
);

    logic [c_DATA_W-1:0] w_shifted;

    always_comb begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        case (st_size_i)
            c_SZ_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_be_o    = 4'b0001 << st_off_i;
            end
            c_SZ_HALF: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // The addressed byte/halfword is brought down to bit 0 before extension.
    assign w_shifted = ld_word_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = w_shifted;
        case (ld_op_i)
            c_LB:    ld_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_LH:    ld_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_LBU:   ld_data_o = {24'd0, w_shifted[7:0]};
            c_LHU:   ld_data_o = {16'd0, w_shifted[15:0]};
            default: ld_data_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
// ============================================================================
// Module   : lsu_bus_ctrl
// Purpose  : Load/store unit bus controller; one bus transaction per access, stalling EX.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [2:0]        ex_mem_rd_op_i,
    input  logic [1:0]        ex_mem_wr_op_i,
    input  logic [DATA_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_stall_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rdata_valid_o,
    output logic              load_misaligned_o,
    output logic              store_misaligned_o,
    lsu_bus_ctrl_if.master    dbus
);

    logic [1:0]        state_q, state_d;
    logic              req_q;
    logic              write_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [2:0]        rd_op_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic              w_idle;
    logic              w_access;
    logic [1:0]        w_size;
    logic              w_mis;
    logic              w_start;
    logic [DATA_W-1:0] w_st_wdata;
    logic [BE_W-1:0]   w_st_be;
    logic [DATA_W-1:0] w_ld_data;

    // A simultaneous load and store is treated as the load.
    always_comb begin
        w_idle             = (state_q == c_ST_IDLE);
        w_access           = ex_mem_rd_i | ex_mem_wr_i;
        w_size             = ex_mem_rd_i ? ex_mem_rd_op_i[1:0] : ex_mem_wr_op_i;
        w_mis              = is_misaligned(w_size, lsu_addr_i[1:0]);
        load_misaligned_o  = w_idle & ex_mem_rd_i & w_mis;
        store_misaligned_o = w_idle & ~ex_mem_rd_i & ex_mem_wr_i & w_mis;
        w_start            = w_idle & w_access & ~w_mis;
        lsu_stall_o        = w_start | (state_q == c_ST_REQ) | (state_q == c_ST_RESP);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_start) state_d = c_ST_REQ;
            c_ST_REQ:  if (dbus.dbus_ready) state_d = write_q ? c_ST_DONE : c_ST_RESP;
            c_ST_RESP: if (dbus.dbus_rvalid) state_d = c_ST_DONE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    lsu_bus_ctrl_align u_align (
        .st_size_i  (w_size),
        .st_off_i   (lsu_addr_i[1:0]),
        .st_data_i  (lsu_wdata_i),
        .st_wdata_o (w_st_wdata),
        .st_be_o    (w_st_be),
        .ld_op_i    (rd_op_q),
        .ld_off_i   (off_q),
        .ld_word_i  (dbus.dbus_rdata),
        .ld_data_o  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            req_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_op_q  <= c_LB;
            off_q    <= 2'b00;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= 1'b0;
            case (state_q)
                c_ST_IDLE: begin
                    if (w_start) begin
                        req_q   <= 1'b1;
                        write_q <= ~ex_mem_rd_i;
                        addr_q  <= {lsu_addr_i[DATA_W-1:2], 2'b00};
                        wdata_q <= w_st_wdata;
                        be_q    <= w_st_be;
                        rd_op_q <= ex_mem_rd_op_i;
                        off_q   <= lsu_addr_i[1:0];
                    end
                end
                c_ST_REQ: begin
                    if (dbus.dbus_ready) req_q <= 1'b0;
                end
                c_ST_RESP: begin
                    if (dbus.dbus_rvalid) begin
                        rdata_q  <= w_ld_data;
                        rvalid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus.dbus_req      = req_q;
    assign dbus.dbus_write    = write_q;
    assign dbus.dbus_addr     = addr_q;
    assign dbus.dbus_wdata    = wdata_q;
    assign dbus.dbus_byte_en  = be_q;
    assign lsu_rdata_o        = rdata_q;
    assign lsu_rdata_valid_o  = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ============================================================================
// Module   : tb_lsu_bus_ctrl
// Purpose  : Directed and randomized self-checking bench for lsu_bus_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        rd_i;
    logic        wr_i;
    logic [2:0]  rd_op_i;
    logic [1:0]  wr_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        ld_mis_o;
    logic        st_mis_o;

    int          total;
    int          bad;
    logic [31:0] exp_rdata;

    lsu_bus_ctrl_if u_if ();

    lsu_bus_ctrl #(.DATA_W(32), .BE_W(4)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .ex_mem_rd_i        (rd_i),
        .ex_mem_wr_i        (wr_i),
        .ex_mem_rd_op_i     (rd_op_i),
        .ex_mem_wr_op_i     (wr_op_i),
        .lsu_addr_i         (addr_i),
        .lsu_wdata_i        (wdata_i),
        .lsu_stall_o        (stall_o),
        .lsu_rdata_o        (rdata_o),
        .lsu_rdata_valid_o  (rvalid_o),
        .load_misaligned_o  (ld_mis_o),
        .store_misaligned_o (st_mis_o),
        .dbus               (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed bytes arithmetically, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] v;
        int          nb;
        nb = 1 << int'(op[1:0]);
        v  = word / (32'd1 << (8 * int'(off)));
        if (nb == 1) begin
            v = v % 256;
            if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v % 65536;
            if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic do_access(input bit ld, input logic [2:0] rop, input logic [1:0] wop,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int rdy_dly, input int rv_dly, input logic [31:0] word);
        int          nb;
        bit          mis;
        logic [3:0]  be;
        logic [31:0] ewd;
        nb  = 1 << (ld ? int'(rop[1:0]) : int'(wop));
        mis = (addr % nb) != 0;
        be  = 4'(((1 << nb) - 1) << int'(addr % 4));
        ewd = (nb == 1) ? 32'(wd % 256) * 32'h0101_0101 :
              (nb == 2) ? 32'(wd % 65536) * 32'h0001_0001 : wd;

        @(negedge clk);
        rd_i = ld; wr_i = !ld; rd_op_i = rop; wr_op_i = wop; addr_i = addr; wdata_i = wd;
        #1;
        chk("idle_ld_mis", ld_mis_o, 32'(ld & mis));
        chk("idle_st_mis", st_mis_o, 32'(!ld & mis));
        chk("idle_stall", stall_o, 32'(!mis));
        chk("idle_req", u_if.dbus_req, 0);
        if (mis) begin
            @(negedge clk);
            chk("mis_noreq", u_if.dbus_req, 0);
            chk("mis_stall", stall_o, 0);
            rd_i = 0; wr_i = 0;
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            @(negedge clk);
            chk("req_req", u_if.dbus_req, 1);
            chk("req_addr", u_if.dbus_addr, addr - (addr % 4));
            chk("req_be", u_if.dbus_byte_en, be);
            chk("req_write", u_if.dbus_write, 32'(!ld));
            chk("req_stall", stall_o, 1);
            if (!ld) chk("req_wdata", u_if.dbus_wdata, ewd);
            u_if.dbus_ready = (k == rdy_dly);
        end
        @(negedge clk);
        u_if.dbus_ready = 0;
        if (ld) begin
            for (int j = 0; j <= rv_dly; j++) begin
                if (j > 0) @(negedge clk);
                chk("resp_stall", stall_o, 1);
                chk("resp_req", u_if.dbus_req, 0);
                chk("resp_valid", rvalid_o, 0);
                u_if.dbus_rvalid = (j == rv_dly);
                u_if.dbus_rdata  = (j == rv_dly) ? word : $urandom;
            end
            @(negedge clk);
            u_if.dbus_rvalid = 0;
            exp_rdata = ref_load(rop, addr[1:0], word);
            chk("done_valid", rvalid_o, 1);
            chk("done_rdata", rdata_o, exp_rdata);
        end
        chk("done_stall", stall_o, 0);
        chk("done_req", u_if.dbus_req, 0);
        @(negedge clk);
        rd_i = 0; wr_i = 0;
        #1;
        chk("post_req", u_if.dbus_req, 0);
        chk("post_valid", rvalid_o, 0);
        chk("post_rdata_hold", rdata_o, exp_rdata);
        chk("post_stall", stall_o, 0);
    endtask

    initial begin
        logic [2:0] ld_ops [5];
        logic [1:0] st_ops [3];
        ld_ops = '{c_LB, c_LH, c_LW, c_LBU, c_LHU};
        st_ops = '{c_SB, c_SH, c_SW};
        total = 0; bad = 0; exp_rdata = 32'd0;
        rst = 1; rd_i = 0; wr_i = 0; rd_op_i = c_LB; wr_op_i = c_SB;
        addr_i = 0; wdata_i = 0;
        u_if.dbus_ready = 0; u_if.dbus_rvalid = 0; u_if.dbus_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_req", u_if.dbus_req, 0);
        chk("rst_write", u_if.dbus_write, 0);
        chk("rst_addr", u_if.dbus_addr, 0);
        chk("rst_wdata", u_if.dbus_wdata, 0);
        chk("rst_be", u_if.dbus_byte_en, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_valid", rvalid_o, 0);
        chk("rst_stall", stall_o, 0);

        do_access(0, c_LB, c_SW, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
        do_access(0, c_LB, c_SB, 32'h203, 32'h0000_00A5, 3, 0, 0);
        do_access(1, c_LB, c_SB, 32'h302, 0, 0, 1, 32'h12F0_3456);
        do_access(1, c_LBU, c_SB, 32'h302, 0, 1, 1, 32'h12F0_3456);
        do_access(1, c_LH, c_SB, 32'h401, 0, 0, 0, 0);
        do_access(0, c_LB, c_SW, 32'h402, 32'h1234_5678, 0, 0, 0);
        do_access(1, c_LHU, c_SB, 32'h502, 0, 0, 0, 32'h8001_ABCD);
        do_access(1, c_LH, c_SB, 32'h502, 0, 2, 3, 32'h8001_ABCD);
        do_access(0, c_LB, c_SH, 32'h602, 32'h0000_BEEF, 1, 0, 0);
        do_access(1, c_LW, c_SB, 32'h700, 0, 0, 0, 32'hCAFE_F00D);

        // Reset while a load waits for its response.
        @(negedge clk);
        rd_i = 1; wr_i = 0; rd_op_i = c_LW; addr_i = 32'h800;
        @(negedge clk);
        u_if.dbus_ready = 1;
        @(negedge clk);
        u_if.dbus_ready = 0;
        chk("rstmid_in_resp", stall_o, 1);
        rst = 1; rd_i = 0;
        @(negedge clk);
        rst = 0;
        #1;
        exp_rdata = 32'd0;
        chk("rstmid_req", u_if.dbus_req, 0);
        chk("rstmid_stall", stall_o, 0);
        chk("rstmid_valid", rvalid_o, 0);
        u_if.dbus_rvalid = 1; u_if.dbus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        u_if.dbus_rvalid = 0;
        chk("late_rvalid_ignored", rvalid_o, 0);
        chk("late_rdata_hold", rdata_o, exp_rdata);

        for (int n = 0; n < 30; n++) begin
            bit          ld;
            logic [31:0] a;
            ld = 1'($urandom_range(0, 1));
            a  = $urandom;
            do_access(ld, ld_ops[$urandom_range(0, 4)], st_ops[$urandom_range(0, 2)], a,
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
